count_en_gen: RTL and testbench

//  Enable generator that sits directly upstream of the 4-bit counter and drives its en input.

---
 rtl/count_en_gen.sv | 115 +++++++++++
 tb/tb_count_en_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_en_gen.sv
// Enable generator for the downstream 4-bit counter: conditions run/step buttons
// (2-FF sync, debounce, press detect) and drives en from an idle/run/step FSM.
module count_en_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  output logic en,
  output logic running
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       run_press;
  logic       step_press;

  assign btn_raw    = {btn_step, btn_run};
  assign run_press  = press[0];
  assign step_press = press[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          deb_reg;
      logic          deb_d_reg;
      logic [CW-1:0] cnt_reg;

      // cnt_reg holds the length of the current run of mismatching samples;
      // the level flips on the DEBOUNCE_CYCLES-th one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          deb_d_reg <= deb_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_reg <= ~deb_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = deb_reg & ~deb_d_reg;
    end
  endgenerate

  state_t        state_reg;
  state_t        state_next;
  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
    end
  end

  // Prescaler is only live in RUN; every other path leaves it at zero.
  always_comb begin
    state_next = state_reg;
    presc_next = '0;
    case (state_reg)
      IDLE: begin
        if (run_press) begin
          state_next = RUN;
        end else if (step_press) begin
          state_next = STEP;
        end
      end
      RUN: begin
        if (run_press) begin
          state_next = IDLE;
        end else if (presc_reg == PW'(PRESCALE - 1)) begin
          presc_next = '0;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      STEP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign running = (state_reg == RUN);
  assign en      = (state_reg == STEP) ||
                   ((state_reg == RUN) && (presc_reg == PW'(PRESCALE - 1)));

endmodule

// File: tb/tb_count_en_gen.sv
// Randomized bench for count_en_gen: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_count_en_gen;

  localparam int D = 4;
  localparam int P = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run = 1'b1;
  logic btn_step = 1'b1;
  logic en;
  logic running;

  int compared = 0;
  int mismatched = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  count_en_gen #(
    .DEBOUNCE_CYCLES(D),
    .PRESCALE(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .en(en),
    .running(running)
  );

  task automatic check(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: debounced level follows a raw level that has been steady for D
  // samples, seen through a 2-edge sync delay; mode tracks cycles spent in RUN.
  bit hist [2][D+2];
  bit m_deb [2];
  bit m_deb_d [2];
  bit m_press [2];
  int m_mode;
  int m_runcyc;
  bit exp_en;
  bit exp_running;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < D + 2; j++) hist[b][j] = 1'b0;
      m_deb[b]   = 1'b0;
      m_deb_d[b] = 1'b0;
    end
    m_mode      = 0;
    m_runcyc    = 0;
    exp_en      = 1'b0;
    exp_running = 1'b0;
  endfunction

  function automatic void model_edge();
    bit steady;
    for (int b = 0; b < 2; b++) begin
      for (int j = D + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      m_press[b] = m_deb[b] & ~m_deb_d[b];
    end
    hist[0][0] = btn_run;
    hist[1][0] = btn_step;
    if (m_mode == 0) begin
      if (m_press[0]) begin
        m_mode   = 1;
        m_runcyc = 0;
      end else if (m_press[1]) begin
        m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (m_press[0]) m_mode = 0;
      else m_runcyc++;
    end else begin
      m_mode = 0;
    end
    for (int b = 0; b < 2; b++) begin
      m_deb_d[b] = m_deb[b];
      steady = 1'b1;
      for (int j = 2; j < D + 2; j++) if (hist[b][j] == m_deb[b]) steady = 1'b0;
      if (steady) m_deb[b] = ~m_deb[b];
    end
    exp_running = (m_mode == 1);
    exp_en      = (m_mode == 2) || ((m_mode == 1) && (m_runcyc % P == P - 1));
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check("cyc_en", en, exp_en);
        check("cyc_running", running, exp_running);
      end
    end
  end

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int pulses;
  int mpulses;
  bit any_high;
  int hr;
  int hs;

  initial begin
    // Reset held with both buttons pressed
    for (int i = 0; i < 3; i++) begin
      step_n(1);
      check("t1_rst_en", en, 1'b0);
      check("t1_rst_running", running, 1'b0);
    end
    rst = 1'b0;
    step_n(6);
    check("t1_running_e6", running, 1'b0);
    step_n(1);
    check("t1_running_e7", running, 1'b1);
    check("t1_model_running_e7", exp_running, 1'b1);
    check("t5_no_step_en", en, 1'b0);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    step_n(12);

    // Second run press returns to IDLE
    btn_run = 1'b1;
    step_n(7);
    check("t5_idle_running", running, 1'b0);
    check("t5_idle_en", en, 1'b0);
    btn_run = 1'b0;
    step_n(12);

    // Short glitch is ignored
    btn_run = 1'b1;
    step_n(3);
    btn_run = 1'b0;
    any_high = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_n(1);
      if (running || en) any_high = 1'b1;
    end
    check("t3_glitch", any_high, 1'b0);

    // Single step in IDLE
    btn_step = 1'b1;
    pulses   = 0;
    any_high = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      step_n(1);
      if (e == 10) btn_step = 1'b0;
      if (e == 7) check("t4_step_e7", en, 1'b1);
      if (e == 8) check("t4_step_e8", en, 1'b0);
      if (en) pulses++;
      if (running) any_high = 1'b1;
    end
    check_int("t4_one_pulse", pulses, 1);
    check("t4_not_running", any_high, 1'b0);

    // RUN cadence, with a step press arriving mid-run
    btn_run = 1'b1;
    pulses  = 0;
    mpulses = 0;
    for (int e = 1; e <= 36; e++) begin
      step_n(1);
      if (e == 10) btn_run = 1'b0;
      if (e == 12) btn_step = 1'b1;
      if (e == 22) btn_step = 1'b0;
      if (e == 6) check("t2_running_e6", running, 1'b0);
      if (e == 7) check("t2_running_e7", running, 1'b1);
      if (e == 8) check("t2_en_e8", en, 1'b0);
      if (e == 9) check("t2_en_e9", en, 1'b1);
      if (e >= 7 && e <= 30) begin
        if (en) pulses++;
        if (exp_en) mpulses++;
      end
    end
    check_int("t2_pulses_24", pulses, 8);
    check_int("t2_model_pulses_24", mpulses, 8);

    // Asynchronous reset between edges while running
    check("t6_pre_running", running, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_en", en, 1'b0);
    check("t6_async_running", running, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step_n(3);
    check("t6_after_running", running, 1'b0);
    check("t6_after_en", en, 1'b0);

    // Random button activity with occasional async resets
    hr = 0;
    hs = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hr == 0) begin
        btn_run = ~btn_run;
        hr = $urandom_range(1, 14);
      end else begin
        hr--;
      end
      if (hs == 0) begin
        btn_step = ~btn_step;
        hs = $urandom_range(1, 14);
      end else begin
        hs--;
      end
      if ($urandom_range(0, 599) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check("rnd_async_en", en, 1'b0);
        check("rnd_async_running", running, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        step_n(1);
      end
    end

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
